// File: rtl/peridot_pfc_cmdbridge.sv
// Avalon-MM slave bridging CPU register accesses onto the 37-bit PFC command bus.
// One transfer in flight; the master is stalled with waitrequest until the DONE cycle.
module peridot_pfc_cmdbridge #(
    parameter int READ_WAIT = 1
) (
    input  logic        csi_clk,
    input  logic        rsi_reset,
    input  logic [3:0]  avs_address,
    input  logic        avs_read,
    input  logic        avs_write,
    input  logic [31:0] avs_writedata,
    output logic [31:0] avs_readdata,
    output logic        avs_waitrequest,
    output logic        coe_pfc_clk,
    output logic        coe_pfc_reset,
    output logic [36:0] coe_pfc_cmd,
    input  logic [31:0] coe_pfc_resp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [2:0] L_READ_WAIT = 3'(READ_WAIT);

    state_t      r_state;
    logic [2:0]  r_cnt;
    logic [36:0] r_cmd;
    logic [31:0] r_rdata;
    logic        r_wait;
    logic        r_pfc_reset;

    // The command register doubles as the address/data latch for the transfer.
    always_ff @(posedge csi_clk) begin
        if (rsi_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_cmd   <= 37'd0;
            r_rdata <= 32'd0;
            r_wait  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_wait <= 1'b1;
                    if (avs_write) begin
                        r_cmd   <= {1'b1, avs_address, avs_writedata};
                        r_state <= S_WR;
                    end else if (avs_read) begin
                        r_cmd   <= {1'b0, avs_address, 32'd0};
                        r_cnt   <= L_READ_WAIT;
                        r_state <= S_RD;
                    end
                end
                S_WR: begin
                    r_cmd[36] <= 1'b0;
                    r_wait    <= 1'b0;
                    r_state   <= S_DONE;
                end
                S_RD: begin
                    if (r_cnt == 3'd0) begin
                        r_rdata <= coe_pfc_resp;
                        r_wait  <= 1'b0;
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_DONE: begin
                    r_wait  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_wait  <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Downstream reset is a plain one-cycle delay of the bus reset.
    always_ff @(posedge csi_clk) begin
        r_pfc_reset <= rsi_reset;
    end

    assign coe_pfc_clk     = csi_clk;
    assign coe_pfc_reset   = r_pfc_reset;
    assign coe_pfc_cmd     = r_cmd;
    assign avs_readdata    = r_rdata;
    assign avs_waitrequest = r_wait;

endmodule

// File: tb/tb_peridot_pfc_cmdbridge.sv
// Directed bench for peridot_pfc_cmdbridge: per-transaction timeline model plus
// a per-cycle compare process and literal expectations.
module tb_peridot_pfc_cmdbridge;

    localparam int RW = 1;

    logic        clk = 1'b0;
    logic        rsi_reset = 1'b1;
    logic [3:0]  avs_address = 4'd0;
    logic        avs_read = 1'b0;
    logic        avs_write = 1'b0;
    logic [31:0] avs_writedata = 32'd0;
    logic [31:0] avs_readdata;
    logic        avs_waitrequest;
    logic        coe_pfc_clk;
    logic        coe_pfc_reset;
    logic [36:0] coe_pfc_cmd;
    logic [31:0] coe_pfc_resp;

    logic [31:0] resp_tab [16];

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;

    logic        chk_en = 1'b0;
    logic        mon_en = 1'b0;
    logic [36:0] exp_cmd = 37'd0;
    logic        exp_wait = 1'b1;
    logic [31:0] exp_rdata = 32'd0;
    logic [35:0] last36 = 36'd0;

    logic [36:0] pulse_q [$];
    int          done_q  [$];

    always #5 clk = ~clk;

    peridot_pfc_cmdbridge #(.READ_WAIT(RW)) dut (
        .csi_clk         (clk),
        .rsi_reset       (rsi_reset),
        .avs_address     (avs_address),
        .avs_read        (avs_read),
        .avs_write       (avs_write),
        .avs_writedata   (avs_writedata),
        .avs_readdata    (avs_readdata),
        .avs_waitrequest (avs_waitrequest),
        .coe_pfc_clk     (coe_pfc_clk),
        .coe_pfc_reset   (coe_pfc_reset),
        .coe_pfc_cmd     (coe_pfc_cmd),
        .coe_pfc_resp    (coe_pfc_resp)
    );

    // Bank register model: response depends only on the addressed bank/register.
    assign coe_pfc_resp = resp_tab[coe_pfc_cmd[35:32]];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (coe_pfc_cmd[36] === 1'b1) pulse_q.push_back(coe_pfc_cmd);
            if (avs_waitrequest === 1'b0) done_q.push_back(cyc);
        end
        if (chk_en) begin
            chk("cmd", 64'(coe_pfc_cmd), 64'(exp_cmd));
            chk("waitrequest", 64'(avs_waitrequest), 64'(exp_wait));
            chk("readdata", 64'(avs_readdata), 64'(exp_rdata));
            chk("pfc_reset", 64'(coe_pfc_reset), 64'd0);
        end
    end

    // Drives one Avalon transfer starting just after a rising edge and sets the
    // expected bus outputs for each cycle of its timeline.
    task automatic do_xfer(input logic rd, input logic wr, input logic [3:0] addr,
                           input logic [31:0] data, output int lat);
        int n;
        logic [35:0] f;
        n   = wr ? 2 : 2 + RW;
        f   = wr ? {addr, data} : {addr, 32'd0};
        lat = -1;
        avs_address   = addr;
        avs_writedata = data;
        avs_read      = rd;
        avs_write     = wr;
        for (int c = 0; c <= n; c++) begin
            if (c == 0) begin
                exp_wait = 1'b1;
                exp_cmd  = {1'b0, last36};
            end else if (c < n) begin
                exp_wait = 1'b1;
                exp_cmd  = {wr, f};
            end else begin
                exp_wait = 1'b0;
                exp_cmd  = {1'b0, f};
                if (!wr) exp_rdata = resp_tab[addr];
            end
            @(negedge clk);
            if (avs_waitrequest === 1'b0 && lat < 0) lat = c;
            @(posedge clk);
            #1;
        end
        avs_read  = 1'b0;
        avs_write = 1'b0;
        last36    = f;
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            exp_wait = 1'b1;
            exp_cmd  = {1'b0, last36};
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int d0;
        for (int i = 0; i < 16; i++) resp_tab[i] = 32'h5000_0000 + 32'(i) * 32'h0101;
        resp_tab[13] = 32'hA5A5_0003;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        chk("pfc_clk_high", 64'(coe_pfc_clk), 64'd1);
        @(negedge clk);
        chk("rst_cmd", 64'(coe_pfc_cmd), 64'd0);
        chk("rst_wait", 64'(avs_waitrequest), 64'd1);
        chk("rst_rdata", 64'(avs_readdata), 64'd0);
        chk("rst_pfc_reset", 64'(coe_pfc_reset), 64'd1);
        chk("pfc_clk_low", 64'(coe_pfc_clk), 64'd0);
        @(posedge clk);
        #1;
        rsi_reset = 1'b0;
        @(negedge clk);
        chk("pfc_reset_still_high", 64'(coe_pfc_reset), 64'd1);
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        chk_en = 1'b1;
        idle_cycles(2);

        // Single write
        pulse_q.delete();
        do_xfer(1'b0, 1'b1, 4'b0110, 32'h0011_0000, lat);
        chk("wr_latency", 64'(lat), 64'd2);
        chk("wr_pulses", 64'(pulse_q.size()), 64'd1);
        if (pulse_q.size() > 0) chk("wr_pulse_cmd", 64'(pulse_q[0]), 64'h16_0011_0000);
        idle_cycles(2);

        // Single read
        pulse_q.delete();
        do_xfer(1'b1, 1'b0, 4'b1101, 32'h0, lat);
        chk("rd_latency", 64'(lat), 64'd3);
        chk("rd_data", 64'(avs_readdata), 64'hA5A5_0003);
        chk("rd_no_pulse", 64'(pulse_q.size()), 64'd0);
        idle_cycles(2);

        // Back-to-back write, read, write
        pulse_q.delete();
        done_q.delete();
        do_xfer(1'b0, 1'b1, 4'b0001, 32'h1234_5678, lat);
        chk("b2b_lat0", 64'(lat), 64'd2);
        do_xfer(1'b1, 1'b0, 4'b1110, 32'h0, lat);
        chk("b2b_lat1", 64'(lat), 64'd3);
        do_xfer(1'b0, 1'b1, 4'b1011, 32'hCAFE_F00D, lat);
        chk("b2b_lat2", 64'(lat), 64'd2);
        chk("b2b_pulses", 64'(pulse_q.size()), 64'd2);
        if (pulse_q.size() == 2) begin
            chk("b2b_bank0", 64'(pulse_q[0][35:34]), 64'd0);
            chk("b2b_bank2", 64'(pulse_q[1][35:34]), 64'd2);
        end
        chk("b2b_dones", 64'(done_q.size()), 64'd3);
        if (done_q.size() == 3) begin
            chk("b2b_gap_rd", 64'(done_q[1] - done_q[0]), 64'd4);
            chk("b2b_gap_wr", 64'(done_q[2] - done_q[1]), 64'd3);
        end
        idle_cycles(2);

        // Read and write together: write wins
        pulse_q.delete();
        do_xfer(1'b1, 1'b1, 4'b0000, 32'h0000_0001, lat);
        chk("rw_latency", 64'(lat), 64'd2);
        chk("rw_pulses", 64'(pulse_q.size()), 64'd1);
        chk("rw_rdata_kept", 64'(avs_readdata), 64'(resp_tab[14]));
        idle_cycles(2);

        // Reset during the WR cycle
        d0 = done_q.size();
        avs_address   = 4'b1010;
        avs_writedata = 32'hDEAD_BEEF;
        avs_write     = 1'b1;
        exp_wait      = 1'b1;
        exp_cmd       = {1'b0, last36};
        @(posedge clk);
        #1;
        exp_cmd   = {1'b1, 4'b1010, 32'hDEAD_BEEF};
        rsi_reset = 1'b1;
        @(posedge clk);
        #1;
        chk_en    = 1'b0;
        rsi_reset = 1'b0;
        avs_write = 1'b0;
        @(negedge clk);
        chk("abort_strobe", 64'(coe_pfc_cmd[36]), 64'd0);
        chk("abort_cmd", 64'(coe_pfc_cmd), 64'd0);
        chk("abort_wait", 64'(avs_waitrequest), 64'd1);
        chk("abort_pfc_reset", 64'(coe_pfc_reset), 64'd1);
        chk("abort_rdata", 64'(avs_readdata), 64'd0);
        @(posedge clk);
        #1;
        last36    = 36'd0;
        exp_rdata = 32'd0;
        exp_cmd   = 37'd0;
        exp_wait  = 1'b1;
        chk_en    = 1'b1;
        idle_cycles(1);
        chk("abort_no_done", 64'(done_q.size()), 64'(d0));
        do_xfer(1'b1, 1'b0, 4'b0101, 32'h0, lat);
        chk("post_rd_latency", 64'(lat), 64'd3);
        chk("post_rd_data", 64'(avs_readdata), 64'h5000_0505);
        idle_cycles(2);

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
